// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the handshaked data-memory responder.
// Holds the FSM state encoding, datapath widths and the access-legality check.
package dmem_responder_pkg;

  localparam int DW_BITS = 64;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // An access is illegal when it is not doubleword aligned or its index is past the array.
  function automatic logic addr_err(input logic [DW_BITS-1:0] addr, input int depth);
    return (addr[2:0] != 3'b000) || ({3'b000, addr[DW_BITS-1:3]} >= 64'(depth));
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// DEPTH x DW storage: synchronous write, combinational read on a shared index.
// Contents are deliberately not reset.
module dmem_responder_array #(
  parameter int DEPTH = 128,
  parameter int DW    = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [DW-1:0]    wdata_i,
  output logic [DW-1:0]    rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle handshaked data memory: one request in flight, programmable wait
// states, error response for misaligned or out-of-range doubleword accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [DW_BITS-1:0] req_addr,
  input  logic [DW_BITS-1:0] req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DW_BITS-1:0] resp_rdata,
  output logic               resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_M1 = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_q;
  logic [DW_BITS-1:0] addr_q;
  logic [DW_BITS-1:0] wdata_q;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic [DW_BITS-1:0] resp_rdata_q;
  logic               resp_err_q;

  logic               accept;
  logic               in_idle;
  logic               enter_resp;
  logic               cm_write;
  logic               cm_err;
  logic               mem_we;
  logic [DW_BITS-1:0] cm_addr;
  logic [DW_BITS-1:0] cm_wdata;
  logic [DW_BITS-1:0] mem_rdata;
  logic [DW_BITS-1:0] resp_rdata_d;
  logic               resp_err_d;
  logic [IDX_W-1:0]   cm_idx;

  assign accept     = req_valid && req_ready_q;
  assign in_idle    = (state_q == S_IDLE);
  assign enter_resp = (in_idle && accept && (LATENCY == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == '0));

  // With zero latency the commit happens on the accept edge, so the live request is used.
  assign cm_write = in_idle ? req_write : wr_q;
  assign cm_addr  = in_idle ? req_addr  : addr_q;
  assign cm_wdata = in_idle ? req_wdata : wdata_q;
  assign cm_err   = addr_err(cm_addr, DEPTH);
  assign cm_idx   = cm_addr[IDX_W+2:3];

  assign mem_we       = enter_resp && cm_write && !cm_err && !reset;
  assign resp_err_d   = cm_err;
  assign resp_rdata_d = (cm_write || cm_err) ? '0 : mem_rdata;

  dmem_responder_array #(
    .DEPTH (DEPTH),
    .DW    (DW_BITS)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .idx_i   (cm_idx),
    .wdata_i (cm_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge CLK) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            cnt_q       <= LAT_M1;
            state_q     <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= resp_rdata_d;
        resp_err_q   <= resp_err_d;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
